// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared widths and state encodings for the mux16 scan sequencer.
package mux16_scan_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux16to1_using_4to1.sv
// 16:1 mux built as a two-level tree of 4:1 muxes.
module mux4to1 (
  input  logic [3:0] in,
  input  logic [1:0] sel,
  output logic       out
);

  assign out = in[sel];

endmodule

module mux16to1_using_4to1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  logic [3:0] w_lvl1;

  mux4to1 u_m0 (.in(in[3:0]),   .sel(sel[1:0]), .out(w_lvl1[0]));
  mux4to1 u_m1 (.in(in[7:4]),   .sel(sel[1:0]), .out(w_lvl1[1]));
  mux4to1 u_m2 (.in(in[11:8]),  .sel(sel[1:0]), .out(w_lvl1[2]));
  mux4to1 u_m3 (.in(in[15:12]), .sel(sel[1:0]), .out(w_lvl1[3]));
  mux4to1 u_m4 (.in(w_lvl1),    .sel(sel[3:2]), .out(out));

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Serialises a latched 16-bit word through the 16:1 mux by stepping sel
// over a wrap-around range, one bit per accepted valid/ready beat.
module mux16_scan_ctrl
  import mux16_scan_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_last;
  logic              w_beat;

  assign w_beat = out_valid & out_ready;
  assign sel    = r_sel;

  always_comb begin
    w_state_nxt = ST_IDLE;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = start ? ST_SEND : ST_IDLE;
      end
      ST_SEND: begin
        out_valid   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = (out_ready && (r_sel == r_last)) ? ST_DONE : ST_SEND;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && start) begin
        r_data <= data_in;
        r_sel  <= first_sel;
        r_last <= last_sel;
      end else if (w_beat && (r_sel != r_last)) begin
        // natural 4-bit overflow gives the 15 -> 0 wrap
        r_sel <= r_sel + 4'd1;
      end
    end
  end

  mux16to1_using_4to1 u_mux (
    .in  (r_data),
    .sel (r_sel),
    .out (out_bit)
  );

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed self-checking bench for mux16_scan_ctrl.
module tb_mux16_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  first_sel;
  logic [3:0]  last_sel;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  sel;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  mux16_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // eb holds the expected bit of beat k in position k; bp selects the
  // ready pattern 1,0,0,1 repeating; poke fires a start mid-scan.
  task automatic do_scan(input logic [15:0] d, input logic [3:0] f, input logic [3:0] l,
                         input logic [15:0] eb, input int n, input bit bp, input bit poke);
    int         beats;
    int         cyc;
    logic [3:0] es;
    logic [3:0] pat;
    logic       rdy;
    beats = 0;
    cyc   = 0;
    es    = f;
    pat   = 4'b1001;
    @(negedge clk);
    start = 1'b1; data_in = d; first_sel = f; last_sel = l; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (beats < n && cyc < 64) begin
      check("valid", {31'd0, out_valid}, 32'd1);
      check("busy",  {31'd0, busy}, 32'd1);
      check("done_low", {31'd0, done}, 32'd0);
      check("sel", {28'd0, sel}, {28'd0, es});
      check("bit", {31'd0, out_bit}, {31'd0, eb[beats]});
      rdy = bp ? pat[cyc % 4] : 1'b1;
      out_ready = rdy;
      if (poke && cyc == 1) begin
        start = 1'b1; data_in = 16'hffff; first_sel = 4'd7; last_sel = 4'd7;
      end else begin
        start = 1'b0;
      end
      if (rdy) begin
        beats++;
        es = es + 4'd1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("beats", beats, n);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_sel", {28'd0, sel}, {28'd0, l});
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_sel", {28'd0, sel}, {28'd0, l});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; first_sel = '0; last_sel = '0; out_ready = 1'b1;
    @(negedge clk);
    // start held high during reset must be ignored
    start = 1'b1; data_in = 16'hffff;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_sel",   {28'd0, sel}, 32'd0);
    check("rst_bit",   {31'd0, out_bit}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // bits of 16'h3f0d: [0..3]=1,0,1,1  [14,15,0,1]=0,0,1,0  [11]=1
    do_scan(16'h3f0d, 4'd0,  4'd3,  16'h000d, 4,  1'b0, 1'b0);
    do_scan(16'h3f0d, 4'd14, 4'd1,  16'h0004, 4,  1'b0, 1'b0);
    do_scan(16'h3f0d, 4'd11, 4'd11, 16'h0001, 1,  1'b0, 1'b0);
    do_scan(16'h3f0d, 4'd0,  4'd15, 16'h3f0d, 16, 1'b0, 1'b0);
    do_scan(16'h3f0d, 4'd0,  4'd3,  16'h000d, 4,  1'b1, 1'b0);
    do_scan(16'h3f0d, 4'd0,  4'd3,  16'h000d, 4,  1'b0, 1'b1);
    // bits of 16'h8421 at 5..9: 1,0,0,0,0 -> accepted right after the poked scan
    do_scan(16'h8421, 4'd5,  4'd9,  16'h0001, 5,  1'b0, 1'b0);

    // reset on the second beat aborts the scan
    @(negedge clk);
    start = 1'b1; data_in = 16'h3f0d; first_sel = 4'd0; last_sel = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_sel0", {28'd0, sel}, 32'd0);
    @(negedge clk);
    check("ab_sel1", {28'd0, sel}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab_valid", {31'd0, out_valid}, 32'd0);
    check("ab_busy",  {31'd0, busy}, 32'd0);
    check("ab_sel",   {28'd0, sel}, 32'd0);
    check("ab_done",  {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ab_no_done", {31'd0, done}, 32'd0);
      check("ab_idle", {31'd0, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux16_scan_ctrl.md
Name: mux16_scan_ctrl

Overview:
Sequencer that serialises a 16-bit word through the team's 16:1 mux (mux16to1_using_4to1) by stepping its 4-bit select over a programmable, wrap-around range.
- Emits one bit per accepted beat on a valid/ready stream.
- Sits between a parallel word source and any bit-serial consumer.
- Owns the mux select; no other logic drives sel.

Parameters:
- none; width fixed at 16 data bits / 4 select bits, to match the existing mux.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin a scan; sampled only in IDLE.
- data_in  input  16  word to serialise; latched on an accepted start.
- first_sel  input  4  first bit index to send; latched on an accepted start.
- last_sel  input  4  last bit index to send; latched on an accepted start.
- out_bit  output  1  data_r[sel], taken from the mux instance output.
- out_valid  output  1  out_bit is valid this cycle.
- out_ready  input  1  consumer accepts the bit when out_valid and out_ready are both 1.
- sel  output  4  current mux select; exported for observation.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous, active-high.
  - On rst: state=IDLE, sel=0, data_r=0, last_r=0, out_valid=0, busy=0, done=0.
  - rst overrides every other input in the same cycle.
- States: IDLE, SEND, DONE. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE:
  - out_valid=0, busy=0.
  - If start=1: data_r<=data_in, sel<=first_sel, last_r<=last_sel, go to SEND.
- SEND:
  - out_valid=1, busy=1.
  - out_bit is combinational from the mux: data_r and sel in, no extra register.
  - On a beat (out_valid & out_ready):
    - if sel==last_r, go to DONE;
    - otherwise sel<=sel+1 modulo 16 (15 wraps to 0).
  - No beat: sel, data_r and state hold. out_bit stays stable under backpressure.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, busy=1.
  - Go to IDLE next cycle.
  - sel holds last_r until the next accepted start.
- Beat count:
  - Beats per scan = ((last_sel - first_sel) mod 16) + 1.
  - first_sel==last_sel sends 1 bit.
  - first_sel = last_sel+1 (mod 16) sends all 16 bits.
- Latency:
  - Start accepted in cycle 0 gives out_valid=1 in cycle 1.
  - With out_ready held at 1, beats occur in cycles 1..N, done=1 in cycle N+1, and the block is back in IDLE (can accept start) in cycle N+2.
- start asserted while busy is ignored; it is not queued.
- Changes to data_in, first_sel or last_sel during a scan have no effect.
- Reset mid-scan aborts the scan: no done pulse, out_valid=0 on the next cycle.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_SEND=2'd1, ST_DONE=2'd2;
  - constants DATA_W=16, SEL_W=4.
- One sub-module: the existing mux16to1_using_4to1, instantiated unchanged with data_r, sel and out_bit.
- Controller FSM and select counter live in mux16_scan_ctrl.

Test Plan:
- Basic scan: data_in=16'h3f0d, first=0, last=3, ready=1 → out_bit 1,0,1,1 in cycles 1-4; done in cycle 5; busy low in cycle 6.
- Wrap-around: data_in=16'h3f0d, first=14, last=1 → sel 14,15,0,1; bits 0,0,1,0; exactly 4 beats.
- Single bit and full scan: data_in=16'h3f0d, first=last=11 → 1 beat, bit=1. first=0, last=15 → 16 beats, in order 1,0,1,1,0,0,0,0,1,1,1,1,1,1,0,0.
- Backpressure: first=0, last=3, ready toggling 1,0,0,1,… → sel and out_bit hold while ready=0; the 4-bit sequence is unchanged; done follows the 4th beat.
- Start while busy: assert start with data_in=16'hffff mid-scan → ignored; the current word completes; a new start after the done-cycle (when back in IDLE) is accepted.
- Reset mid-scan: assert rst on the 2nd beat → the next cycle shows out_valid=0, busy=0, sel=0, and no done pulse.
